cache_write_back: RTL and testbench
===================================

// Module: cache_write_back
// PURPOSE
//  Parametrised direct-mapped write-back data cache; successor of the write-through-only line cache.
//  Adds configurable line size and byte-enable writes. Refills/evictions via a burst memory port.
//  Sits between the CPU load/store unit (cmd/rsp side) and the burst RAM controller (mem side).
// PARAMETERS
//  ADDR_BITWIDTH            32  byte address width; data width fixed at 32, bits [1:0] ignored
//  LINE_IX_BITWIDTH         10  number of lines = 2**LINE_IX_BITWIDTH
//  WORD_IX_BITWIDTH          2  words per line = 2**WORD_IX_BITWIDTH (burst length)
//  Derived: word = addr[WORD_IX_BITWIDTH+1:2], line = next LINE_IX_BITWIDTH bits, tag = remaining high bits
// PORTS
//  clk               in   1   clock, all logic on rising edge
//  rst               in   1   reset, asynchronous, active-high
//  cmd_valid         in   1   request present
//  cmd_ready         out  1   request accepted when cmd_valid && cmd_ready
//  cmd_address       in   ADDR_BITWIDTH  byte address
//  cmd_write_enable  in   4   byte enables; 4'b0000 = read
//  cmd_data_in       in   32  write data
//  rsp_valid         out  1   one-cycle pulse per accepted request
//  rsp_data          out  32  read word, or merged word after a write
//  mem_cmd_valid     out  1   burst command present
//  mem_cmd_ready     in   1   burst command accepted
//  mem_cmd_write     out  1   1 = write-back burst, 0 = fill burst
//  mem_cmd_address   out  ADDR_BITWIDTH  line-aligned burst address (word/byte bits zero)
//  mem_wdata         out  32  write-back beat, word 0 first
//  mem_wdata_valid   out  1   beat present; transfers when mem_wdata_ready
//  mem_wdata_ready   in   1   memory accepts beat
//  mem_rdata         in   32  fill beat, word 0 first
//  mem_rdata_valid   in   1   fill beat strobe; memory cannot be stalled by the cache
// BEHAVIOUR
//  Storage: tag + data in sync RAMs (1-cycle read); valid/dirty bits in flops, cleared asynchronously by rst.
//  Reset: state IDLE; cmd_ready, rsp_valid, mem_cmd_valid, mem_cmd_write, mem_wdata_valid = 0; rsp_data = 0.
//  States: IDLE -> LOOKUP -> (hit) IDLE/LOOKUP; miss clean -> FILL_CMD; miss dirty -> WB_CMD -> WB_DATA -> FILL_CMD
//    -> FILL_DATA -> RESPOND -> IDLE.
//  cmd_ready: high in IDLE (after reset release); in LOOKUP high only if the pending lookup hits; low otherwise.
//  Hit latency: rsp_valid exactly 1 cycle after acceptance; back-to-back hits sustain 1 request/cycle.
//  Write hit: bytes merged per cmd_write_enable, line marked dirty, no memory traffic.
//  Forwarding: a request to the same word as the previous cycle's write hit sees the merged data.
//  Miss: request latched; cmd_ready low until rsp_valid. Dirty victim written back first (address = victim tag+line).
//  WB_CMD/FILL_CMD: mem_cmd_valid and mem_cmd_* held stable until mem_cmd_ready.
//  WB_DATA: 2**WORD_IX_BITWIDTH beats, mem_wdata stable while mem_wdata_valid && !mem_wdata_ready.
//  FILL_DATA: beat counter wraps at line size; last beat writes tag, valid=1, dirty=(write request).
//  Pending write merged into its word as it is filled. RESPOND: rsp_valid pulse with requested word, next cycle IDLE.
//  Simultaneous: mem_cmd_ready in same cycle as command raise = accepted that cycle; extra mem_rdata_valid outside FILL_DATA ignored.
//  Reset mid-operation (any state, incl. mid-burst): immediate IDLE, all lines invalid, dirty data discarded,
//    no rsp_valid for the aborted request; memory controller shares rst.
// TESTING (defaults; line = 16 bytes, index = addr[13:4])
//  1 reset, read 0x4 -> mem_cmd read @0x0; beats 0x1111_1111,0x2222_2222,0x3333_3333,0x4444_4444 -> rsp 0x2222_2222
//  2 write 0x8 data 0xabcd_1234 be 4'b1111, then read 0x8 next cycle -> two rsp pulses, 2nd = 0xabcd_1234, no mem_cmd
//  3 write 0x4 data 0x0000_00ff be 4'b0001, read 0x4 -> rsp 0x2222_22ff
//  4 read 0x4004 -> write-back @0x0 beats 0x1111_1111,0x2222_22ff,0xabcd_1234,0x4444_4444; fill @0x4000; rsp = fill beat 1
//  5 hold mem_cmd_ready / mem_wdata_ready low 5 cycles -> mem_* outputs stable, cmd_ready = 0, no rsp_valid
//  6 assert rst during 3rd fill beat -> outputs 0 same cycle; afterwards read 0x4 misses again (mem_cmd read @0x0)

Source files
------------

// File: rtl/cache_write_back.sv
// Direct-mapped write-back data cache with byte-enable writes and a burst refill/evict port.
// Tags and data live in 1-cycle synchronous RAMs; valid/dirty bits are flops cleared by rst.
`timescale 1ns/1ps
module cache_write_back #(
  parameter int unsigned ADDR_BITWIDTH    = 32,
  parameter int unsigned LINE_IX_BITWIDTH = 10,
  parameter int unsigned WORD_IX_BITWIDTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [ADDR_BITWIDTH-1:0] cmd_address,
  input  logic [3:0]               cmd_write_enable,
  input  logic [31:0]              cmd_data_in,
  output logic                     rsp_valid,
  output logic [31:0]              rsp_data,
  output logic                     mem_cmd_valid,
  input  logic                     mem_cmd_ready,
  output logic                     mem_cmd_write,
  output logic [ADDR_BITWIDTH-1:0] mem_cmd_address,
  output logic [31:0]              mem_wdata,
  output logic                     mem_wdata_valid,
  input  logic                     mem_wdata_ready,
  input  logic [31:0]              mem_rdata,
  input  logic                     mem_rdata_valid
);
  localparam int unsigned LsbW  = WORD_IX_BITWIDTH + 2;
  localparam int unsigned TagW  = ADDR_BITWIDTH - LINE_IX_BITWIDTH - LsbW;
  localparam int unsigned WaW   = ADDR_BITWIDTH - 2;
  localparam int unsigned Lines = 2 ** LINE_IX_BITWIDTH;
  localparam int unsigned Words = 2 ** (LINE_IX_BITWIDTH + WORD_IX_BITWIDTH);

  typedef logic [TagW-1:0]             tag_t;
  typedef logic [LINE_IX_BITWIDTH-1:0] line_t;
  typedef logic [WORD_IX_BITWIDTH-1:0] word_t;

  typedef enum logic [2:0] {
    StIdle, StLookup, StWbCmd, StWbData, StFillCmd, StFillData, StRespond
  } state_e;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  be);
    logic [31:0] w;
    w = old_w;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) w[8*b +: 8] = new_w[8*b +: 8];
    end
    return w;
  endfunction

  state_e             state_q, state_d;
  logic [WaW-1:0]     req_wa_q, req_wa_d, fwd_wa_q, fwd_wa_d;
  logic [3:0]         req_be_q, req_be_d;
  logic [31:0]        req_data_q, req_data_d, fwd_data_q, fwd_data_d;
  word_t              beat_q, beat_d;
  logic [Lines-1:0]   valid_q, valid_d, dirty_q, dirty_d;
  logic               fwd_valid_q, fwd_valid_d, rsp_valid_q, rsp_valid_d;
  logic [31:0]        rsp_data_q, rsp_data_d;
  logic               mem_cmd_valid_q, mem_cmd_valid_d, mem_cmd_write_q, mem_cmd_write_d;
  logic [ADDR_BITWIDTH-1:0] mem_cmd_addr_q, mem_cmd_addr_d;
  logic               mem_wdata_valid_q, mem_wdata_valid_d;

  tag_t               tag_ram [Lines];
  logic [31:0]        data_ram [Words];
  tag_t               tag_rd_q;
  logic [31:0]        data_rd_q;
  line_t              tag_ra;
  logic [LINE_IX_BITWIDTH+WORD_IX_BITWIDTH-1:0] data_ra, data_wa;
  logic               data_we, tag_we;
  logic [31:0]        data_wd;

  tag_t  req_tag;
  line_t req_line, cmd_line;
  word_t req_word, cmd_word;
  logic  hit, accept, is_write, last_beat, wb_beat;
  logic [31:0] cur_word, hit_word, fill_word;
  logic  unused_addr_lsb;

  assign unused_addr_lsb = ^cmd_address[1:0];
  assign req_tag  = req_wa_q[WaW-1 -: TagW];
  assign req_line = req_wa_q[WORD_IX_BITWIDTH +: LINE_IX_BITWIDTH];
  assign req_word = req_wa_q[WORD_IX_BITWIDTH-1:0];
  assign cmd_line = cmd_address[LsbW +: LINE_IX_BITWIDTH];
  assign cmd_word = cmd_address[2 +: WORD_IX_BITWIDTH];

  assign hit       = (state_q == StLookup) && valid_q[req_line] && (tag_rd_q == req_tag);
  assign cmd_ready = !rst && ((state_q == StIdle) || hit);
  assign accept    = cmd_valid && cmd_ready;
  assign is_write  = |req_be_q;
  // The RAM read races the previous cycle's write hit, so take the merged word from the bypass.
  assign cur_word  = (fwd_valid_q && fwd_wa_q == req_wa_q) ? fwd_data_q : data_rd_q;
  assign hit_word  = merge_bytes(cur_word, req_data_q, req_be_q);
  assign fill_word = (beat_q == req_word) ? merge_bytes(mem_rdata, req_data_q, req_be_q)
                                          : mem_rdata;
  assign last_beat = (beat_q == '1);
  assign wb_beat   = mem_wdata_valid_q && mem_wdata_ready;

  always_comb begin
    state_d     = state_q;
    req_wa_d    = req_wa_q;
    req_be_d    = req_be_q;
    req_data_d  = req_data_q;
    beat_d      = beat_q;
    valid_d     = valid_q;
    dirty_d     = dirty_q;
    fwd_valid_d = 1'b0;
    fwd_wa_d    = fwd_wa_q;
    fwd_data_d  = fwd_data_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    mem_cmd_addr_d = mem_cmd_addr_q;
    data_we = 1'b0;
    tag_we  = 1'b0;
    data_wa = {req_line, req_word};
    data_wd = hit_word;
    data_ra = {req_line, req_word};
    tag_ra  = req_line;
    if (accept) begin
      req_wa_d   = cmd_address[ADDR_BITWIDTH-1:2];
      req_be_d   = cmd_write_enable;
      req_data_d = cmd_data_in;
      data_ra    = {cmd_line, cmd_word};
      tag_ra     = cmd_line;
    end
    unique case (state_q)
      StIdle: if (accept) state_d = StLookup;
      StLookup: begin
        if (hit) begin
          rsp_valid_d = 1'b1;
          rsp_data_d  = hit_word;
          if (is_write) begin
            data_we           = 1'b1;
            dirty_d[req_line] = 1'b1;
            fwd_valid_d       = 1'b1;
            fwd_wa_d          = req_wa_q;
            fwd_data_d        = hit_word;
          end
          state_d = accept ? StLookup : StIdle;
        end else if (valid_q[req_line] && dirty_q[req_line]) begin
          state_d        = StWbCmd;
          mem_cmd_addr_d = {tag_rd_q, req_line, {LsbW{1'b0}}};
        end else begin
          state_d        = StFillCmd;
          mem_cmd_addr_d = {req_tag, req_line, {LsbW{1'b0}}};
        end
      end
      StWbCmd: begin
        beat_d  = '0;
        data_ra = {req_line, {WORD_IX_BITWIDTH{1'b0}}};
        if (mem_cmd_ready) state_d = StWbData;
      end
      StWbData: begin
        if (wb_beat) beat_d = beat_q + 1'b1;
        // Read one beat ahead so mem_wdata already holds the next word after a transfer.
        data_ra = {req_line, beat_d};
        if (wb_beat && last_beat) begin
          state_d        = StFillCmd;
          mem_cmd_addr_d = {req_tag, req_line, {LsbW{1'b0}}};
        end
      end
      StFillCmd: begin
        beat_d = '0;
        if (mem_cmd_ready) state_d = StFillData;
      end
      StFillData: begin
        if (mem_rdata_valid) begin
          data_we = 1'b1;
          data_wa = {req_line, beat_q};
          data_wd = fill_word;
          beat_d  = beat_q + 1'b1;
          if (beat_q == req_word) rsp_data_d = fill_word;
          if (last_beat) begin
            tag_we            = 1'b1;
            valid_d[req_line] = 1'b1;
            dirty_d[req_line] = is_write;
            rsp_valid_d       = 1'b1;
            state_d           = StRespond;
          end
        end
      end
      StRespond: state_d = StIdle;
      default:   state_d = StIdle;
    endcase
    mem_cmd_valid_d   = (state_d == StWbCmd) || (state_d == StFillCmd);
    mem_cmd_write_d   = (state_d == StWbCmd);
    mem_wdata_valid_d = (state_d == StWbData);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q           <= StIdle;
      req_wa_q          <= '0;
      req_be_q          <= '0;
      req_data_q        <= '0;
      beat_q            <= '0;
      valid_q           <= '0;
      dirty_q           <= '0;
      fwd_valid_q       <= 1'b0;
      fwd_wa_q          <= '0;
      fwd_data_q        <= '0;
      rsp_valid_q       <= 1'b0;
      rsp_data_q        <= '0;
      mem_cmd_valid_q   <= 1'b0;
      mem_cmd_write_q   <= 1'b0;
      mem_cmd_addr_q    <= '0;
      mem_wdata_valid_q <= 1'b0;
    end else begin
      state_q           <= state_d;
      req_wa_q          <= req_wa_d;
      req_be_q          <= req_be_d;
      req_data_q        <= req_data_d;
      beat_q            <= beat_d;
      valid_q           <= valid_d;
      dirty_q           <= dirty_d;
      fwd_valid_q       <= fwd_valid_d;
      fwd_wa_q          <= fwd_wa_d;
      fwd_data_q        <= fwd_data_d;
      rsp_valid_q       <= rsp_valid_d;
      rsp_data_q        <= rsp_data_d;
      mem_cmd_valid_q   <= mem_cmd_valid_d;
      mem_cmd_write_q   <= mem_cmd_write_d;
      mem_cmd_addr_q    <= mem_cmd_addr_d;
      mem_wdata_valid_q <= mem_wdata_valid_d;
    end
  end

  always_ff @(posedge clk) begin
    tag_rd_q  <= tag_ram[tag_ra];
    data_rd_q <= data_ram[data_ra];
    if (tag_we)  tag_ram[req_line] <= req_tag;
    if (data_we) data_ram[data_wa] <= data_wd;
  end

  assign rsp_valid       = rsp_valid_q;
  assign rsp_data        = rsp_data_q;
  assign mem_cmd_valid   = mem_cmd_valid_q;
  assign mem_cmd_write   = mem_cmd_write_q;
  assign mem_cmd_address = mem_cmd_addr_q;
  assign mem_wdata       = data_rd_q;
  assign mem_wdata_valid = mem_wdata_valid_q;
endmodule

// File: tb/tb_cache_write_back.sv
// Directed bench for cache_write_back: hits, forwarding, fills, write-backs, stalls, mid-burst reset.
`timescale 1ns/1ps
module tb_cache_write_back;
  typedef logic [31:0] beats_t [4];

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] cmd_address = '0;
  logic [3:0]  cmd_write_enable = '0;
  logic [31:0] cmd_data_in = '0;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        mem_cmd_valid;
  logic        mem_cmd_ready = 1'b0;
  logic        mem_cmd_write;
  logic [31:0] mem_cmd_address;
  logic [31:0] mem_wdata;
  logic        mem_wdata_valid;
  logic        mem_wdata_ready = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        mem_rdata_valid = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;
  beats_t b;

  always #5 clk = ~clk;

  cache_write_back dut (
    .clk              (clk),
    .rst              (rst),
    .cmd_valid        (cmd_valid),
    .cmd_ready        (cmd_ready),
    .cmd_address      (cmd_address),
    .cmd_write_enable (cmd_write_enable),
    .cmd_data_in      (cmd_data_in),
    .rsp_valid        (rsp_valid),
    .rsp_data         (rsp_data),
    .mem_cmd_valid    (mem_cmd_valid),
    .mem_cmd_ready    (mem_cmd_ready),
    .mem_cmd_write    (mem_cmd_write),
    .mem_cmd_address  (mem_cmd_address),
    .mem_wdata        (mem_wdata),
    .mem_wdata_valid  (mem_wdata_valid),
    .mem_wdata_ready  (mem_wdata_ready),
    .mem_rdata        (mem_rdata),
    .mem_rdata_valid  (mem_rdata_valid)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic issue(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
    cmd_valid = 1'b1; cmd_address = a; cmd_write_enable = be; cmd_data_in = d;
    check_eq("issue_ready", cmd_ready, 1);
    cyc();
    cmd_valid = 1'b0;
  endtask

  task automatic hit_access(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d,
                            input logic [31:0] exp);
    issue(a, be, d);
    check_eq("hit_lookup_ready", cmd_ready, 1);
    cyc();
    check_eq("hit_rsp_valid", rsp_valid, 1);
    check_eq("hit_rsp_data", rsp_data, exp);
    check_eq("hit_no_mem_cmd", mem_cmd_valid, 0);
    cyc();
    check_eq("hit_rsp_pulse", rsp_valid, 0);
  endtask

  // Write immediately followed by an access to the same word (exercises the bypass).
  task automatic hit_pair(input logic [31:0] a, input logic [3:0] be1, input logic [31:0] d1,
                          input logic [31:0] e1, input logic [3:0] be2, input logic [31:0] e2);
    cmd_valid = 1'b1; cmd_address = a; cmd_write_enable = be1; cmd_data_in = d1;
    check_eq("pair_ready0", cmd_ready, 1);
    cyc();
    cmd_write_enable = be2; cmd_data_in = '0;
    check_eq("pair_ready1", cmd_ready, 1);
    cyc();
    cmd_valid = 1'b0;
    check_eq("pair_rsp0_valid", rsp_valid, 1);
    check_eq("pair_rsp0_data", rsp_data, e1);
    cyc();
    check_eq("pair_rsp1_valid", rsp_valid, 1);
    check_eq("pair_rsp1_data", rsp_data, e2);
    check_eq("pair_no_mem_cmd", mem_cmd_valid, 0);
    cyc();
    check_eq("pair_rsp_pulse", rsp_valid, 0);
  endtask

  // Waits for a burst command, checks it, accepts it and drives a stray fill beat alongside.
  task automatic take_mem_cmd(input logic w, input logic [31:0] a);
    int k = 0;
    while (!mem_cmd_valid && k < 20) begin cyc(); k++; end
    check_eq("mem_cmd_valid", mem_cmd_valid, 1);
    check_eq("mem_cmd_write", mem_cmd_write, w);
    check_eq("mem_cmd_address", mem_cmd_address, a);
    check_eq("busy_cmd_ready", cmd_ready, 0);
    mem_cmd_ready = 1'b1; mem_rdata_valid = 1'b1; mem_rdata = 32'hdead_beef;
    cyc();
    mem_cmd_ready = 1'b0; mem_rdata_valid = 1'b0;
  endtask

  task automatic drain_wb(input beats_t exp);
    int k = 0;
    while (!mem_wdata_valid && k < 20) begin cyc(); k++; end
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("wb_valid%0d", i), mem_wdata_valid, 1);
      check_eq($sformatf("wb_beat%0d", i), mem_wdata, exp[i]);
      mem_wdata_ready = 1'b1;
      cyc();
    end
    mem_wdata_ready = 1'b0;
    check_eq("wb_done", mem_wdata_valid, 0);
  endtask

  task automatic fill(input beats_t beats);
    for (int i = 0; i < 4; i++) begin
      mem_rdata_valid = 1'b1; mem_rdata = beats[i];
      check_eq("fill_no_rsp", rsp_valid, 0);
      cyc();
    end
    mem_rdata_valid = 1'b0;
  endtask

  task automatic expect_rsp(input logic [31:0] exp);
    int k = 0;
    while (!rsp_valid && k < 10) begin cyc(); k++; end
    check_eq("miss_rsp_valid", rsp_valid, 1);
    check_eq("miss_rsp_data", rsp_data, exp);
    cyc();
    check_eq("miss_rsp_pulse", rsp_valid, 0);
    check_eq("idle_ready", cmd_ready, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    cyc(); cyc();
    check_eq("rst_cmd_ready", cmd_ready, 0);
    check_eq("rst_rsp_valid", rsp_valid, 0);
    check_eq("rst_rsp_data", rsp_data, 0);
    check_eq("rst_mem_cmd_valid", mem_cmd_valid, 0);
    check_eq("rst_mem_cmd_write", mem_cmd_write, 0);
    check_eq("rst_mem_wdata_valid", mem_wdata_valid, 0);
    rst = 1'b0;
    cyc();
    check_eq("post_rst_ready", cmd_ready, 1);

    // 1: clean read miss
    issue(32'h4, 4'b0000, '0);
    check_eq("miss_lookup_ready", cmd_ready, 0);
    take_mem_cmd(1'b0, 32'h0);
    b = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};
    fill(b);
    expect_rsp(32'h2222_2222);

    // 2, 3: write hits with back-to-back reads of the same word
    hit_pair(32'h8, 4'b1111, 32'habcd_1234, 32'habcd_1234, 4'b0000, 32'habcd_1234);
    hit_pair(32'h4, 4'b0001, 32'h0000_00ff, 32'h2222_22ff, 4'b0000, 32'h2222_22ff);

    // 4: dirty miss -> write-back then fill
    issue(32'h4004, 4'b0000, '0);
    take_mem_cmd(1'b1, 32'h0);
    b = '{32'h1111_1111, 32'h2222_22ff, 32'habcd_1234, 32'h4444_4444};
    drain_wb(b);
    take_mem_cmd(1'b0, 32'h4000);
    b = '{32'h0f0f_0000, 32'h0f0f_1111, 32'h0f0f_2222, 32'h0f0f_3333};
    fill(b);
    expect_rsp(32'h0f0f_1111);

    // 5: stalled write-back command and data
    hit_access(32'h4000, 4'b1111, 32'h5a5a_5a5a, 32'h5a5a_5a5a);
    issue(32'h0, 4'b0000, '0);
    cyc();
    for (int i = 0; i < 5; i++) begin
      check_eq("stall_cmd_valid", mem_cmd_valid, 1);
      check_eq("stall_cmd_write", mem_cmd_write, 1);
      check_eq("stall_cmd_addr", mem_cmd_address, 32'h4000);
      check_eq("stall_cmd_ready", cmd_ready, 0);
      check_eq("stall_rsp_valid", rsp_valid, 0);
      cyc();
    end
    take_mem_cmd(1'b1, 32'h4000);
    for (int i = 0; i < 5; i++) begin
      check_eq("stall_wdata_valid", mem_wdata_valid, 1);
      check_eq("stall_wdata", mem_wdata, 32'h5a5a_5a5a);
      check_eq("stall_wb_ready", cmd_ready, 0);
      check_eq("stall_wb_rsp", rsp_valid, 0);
      cyc();
    end
    b = '{32'h5a5a_5a5a, 32'h0f0f_1111, 32'h0f0f_2222, 32'h0f0f_3333};
    drain_wb(b);
    take_mem_cmd(1'b0, 32'h0);
    b = '{32'hc0c0_c0c0, 32'hc1c1_c1c1, 32'hc2c2_c2c2, 32'hc3c3_c3c3};
    fill(b);
    expect_rsp(32'hc0c0_c0c0);

    // 6: reset during the third fill beat
    issue(32'h8000, 4'b0000, '0);
    take_mem_cmd(1'b0, 32'h8000);
    mem_rdata_valid = 1'b1; mem_rdata = 32'hd0d0_d0d0; cyc();
    mem_rdata = 32'hd1d1_d1d1; cyc();
    mem_rdata = 32'hd2d2_d2d2; rst = 1'b1;
    #1;
    check_eq("abort_rsp_valid", rsp_valid, 0);
    check_eq("abort_rsp_data", rsp_data, 0);
    check_eq("abort_cmd_ready", cmd_ready, 0);
    check_eq("abort_mem_cmd_valid", mem_cmd_valid, 0);
    check_eq("abort_wdata_valid", mem_wdata_valid, 0);
    cyc();
    rst = 1'b0; mem_rdata_valid = 1'b0;
    cyc();
    check_eq("abort_no_rsp", rsp_valid, 0);
    check_eq("abort_ready", cmd_ready, 1);
    issue(32'h4, 4'b0000, '0);
    take_mem_cmd(1'b0, 32'h0);
    b = '{32'hd0d0_d0d0, 32'hd1d1_d1d1, 32'hd2d2_d2d2, 32'hd3d3_d3d3};
    fill(b);
    expect_rsp(32'hd1d1_d1d1);

    // 7: write miss merges into the filled word and leaves the line dirty
    issue(32'h4008, 4'b1100, 32'h7766_0000);
    take_mem_cmd(1'b0, 32'h4000);
    b = '{32'he0e0_e0e0, 32'he1e1_e1e1, 32'he2e2_e2e2, 32'he3e3_e3e3};
    fill(b);
    expect_rsp(32'h7766_e2e2);
    hit_access(32'h4008, 4'b0000, '0, 32'h7766_e2e2);
    issue(32'h8, 4'b0000, '0);
    take_mem_cmd(1'b1, 32'h4000);
    b = '{32'he0e0_e0e0, 32'he1e1_e1e1, 32'h7766_e2e2, 32'he3e3_e3e3};
    drain_wb(b);
    take_mem_cmd(1'b0, 32'h0);
    b = '{32'h9090_9090, 32'h9191_9191, 32'h9292_9292, 32'h9393_9393};
    fill(b);
    expect_rsp(32'h9292_9292);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
